// File: rtl/serial_pkg.sv
// serial_pkg: constants, field positions and helpers shared by the SFP serial transmitter and receiver
package serial_pkg;
  localparam int BITS_PER_SYM = 10;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [BITS_PER_SYM-1:0] K28_5_RDN = 10'b0011111010;
  localparam logic [BITS_PER_SYM-1:0] K28_5_RDP = 10'b1100000101;
  localparam int PRO = 7;
  localparam int MST = 6;
  localparam int PLS = 5;
  localparam int P1 = 4;
  localparam int OPT_HI = 3;
  localparam int OPT_LO = 1;
  localparam int P2 = 0;
  typedef enum logic {RD_NEG = 1'b0, RD_POS = 1'b1} rd_e;
  // Each nibble carries odd parity, so a stuck-at-zero byte never decodes as valid
  function automatic logic [7:0] make_byte(input logic pro, mst, pls, input logic [2:0] opt);
    logic [7:0] b;
    b = '0;
    b[PRO] = pro;
    b[MST] = mst;
    b[PLS] = pls;
    b[P1] = ~^{pro, mst, pls};
    b[OPT_HI:OPT_LO] = opt;
    b[P2] = ~^opt;
    return b;
  endfunction
  // Codes are abcdeifghj with a in the MSB; the line sends a first from bit 0
  function automatic logic [BITS_PER_SYM-1:0] line_order(input logic [BITS_PER_SYM-1:0] c);
    logic [BITS_PER_SYM-1:0] r;
    for (int i = 0; i < BITS_PER_SYM; i++) r[i] = c[BITS_PER_SYM-1-i];
    return r;
  endfunction
endpackage

// File: rtl/serial_tx_if.sv
// serial_tx_if: control fields in and SFP pins out of the serial transmitter
interface serial_tx_if;
  logic       IsPro;
  logic       IsMaster;
  logic       RawPls;
  logic [2:0] Option;
  logic       SerialData;
  logic       tx_dis;
  logic [1:0] tx_led;
  modport master(output IsPro, IsMaster, RawPls, Option, input SerialData, tx_dis, tx_led);
  modport slave(input IsPro, IsMaster, RawPls, Option, output SerialData, tx_dis, tx_led);
endinterface

// File: rtl/encode_8b10b.sv
// encode_8b10b: combinational 8b/10b encoder, datain[8] = K flag, dataout = abcdeifghj with a in bit 9
module encode_8b10b (
  input  logic [8:0] datain,
  input  logic       dispin,
  output logic [9:0] dataout,
  output logic       dispout
);
  logic [4:0] x;
  logic [2:0] y;
  logic       k, k28, unbal6, unbal4, rd6, alt7;
  logic [5:0] c6n, c6;
  logic [3:0] c4n, c4;
  assign {k, y, x} = datain;
  always_comb begin
    k28 = k && x == 5'd28;
    case (x)
      5'd0:  c6n = 6'b100111;
      5'd1:  c6n = 6'b011101;
      5'd2:  c6n = 6'b101101;
      5'd3:  c6n = 6'b110001;
      5'd4:  c6n = 6'b110101;
      5'd5:  c6n = 6'b101001;
      5'd6:  c6n = 6'b011001;
      5'd7:  c6n = 6'b111000;
      5'd8:  c6n = 6'b111001;
      5'd9:  c6n = 6'b100101;
      5'd10: c6n = 6'b010101;
      5'd11: c6n = 6'b110100;
      5'd12: c6n = 6'b001101;
      5'd13: c6n = 6'b101100;
      5'd14: c6n = 6'b011100;
      5'd15: c6n = 6'b010111;
      5'd16: c6n = 6'b011011;
      5'd17: c6n = 6'b100011;
      5'd18: c6n = 6'b010011;
      5'd19: c6n = 6'b110010;
      5'd20: c6n = 6'b001011;
      5'd21: c6n = 6'b101010;
      5'd22: c6n = 6'b011010;
      5'd23: c6n = 6'b111010;
      5'd24: c6n = 6'b110011;
      5'd25: c6n = 6'b100110;
      5'd26: c6n = 6'b010110;
      5'd27: c6n = 6'b110110;
      5'd28: c6n = 6'b001110;
      5'd29: c6n = 6'b101110;
      5'd30: c6n = 6'b011110;
      default: c6n = 6'b101011;
    endcase
    if (k28) c6n = 6'b001111;
    // D.7 is balanced but still flips polarity at RD+ to avoid a run of five
    unbal6 = $countones(c6n) != 3;
    c6 = dispin && (unbal6 || x == 5'd7) ? ~c6n : c6n;
    rd6 = dispin ^ unbal6;
    alt7 = y == 3'd7 && (k || (rd6 ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                                   : (x == 5'd17 || x == 5'd18 || x == 5'd20)));
    case (y)
      3'd0: c4n = 4'b1011;
      3'd1: c4n = 4'b1001;
      3'd2: c4n = 4'b0101;
      3'd3: c4n = 4'b1100;
      3'd4: c4n = 4'b1101;
      3'd5: c4n = 4'b1010;
      3'd6: c4n = 4'b0110;
      default: c4n = alt7 ? 4'b0111 : 4'b1110;
    endcase
    unbal4 = $countones(c4n) != 2;
    // K28.y with y in 1,2,5,6 inverts the balanced D code so the comma stays singular
    c4 = (rd6 && (unbal4 || y == 3'd3)) || (k28 && !rd6 && y[1] != y[0]) ? ~c4n : c4n;
    dataout = {c6, c4};
    dispout = rd6 ^ unbal4;
  end
endmodule

// File: rtl/serial_tx.sv
// serial_tx: frames control fields into 8b/10b symbols with a K28.5 comma every FRAME_LEN symbols
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLK_PER_BIT = 4,
  parameter int FRAME_LEN   = 256
) (
  input  logic       i_clk,
  input  logic       i_res_n,
  input  logic       i_IsPro,
  input  logic       i_IsMaster,
  input  logic       i_RawPls,
  input  logic [2:0] i_Option,
  output logic       o_SerialData,
  output logic       o_tx_dis,
  output logic [1:0] o_tx_led
);
  localparam int CW = CLK_PER_BIT > 1 ? $clog2(CLK_PER_BIT) : 1;
  localparam int SW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [SW-1:0] SYM_LAST = SW'(FRAME_LEN - 1);
  localparam logic [3:0] BIT_LAST = 4'(BITS_PER_SYM - 1);
  logic [CW-1:0] clkdiv_q, clkdiv_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [SW-1:0] symcnt_q, symcnt_d;
  logic [BITS_PER_SYM-1:0] shreg_q, shreg_d, enc_code;
  rd_e rd_q, rd_d;
  logic pls_q, pls_d, enc_rd, tick, load, comma;
  logic [8:0] enc_in;
  encode_8b10b u_enc (
    .datain (enc_in),
    .dispin (rd_q),
    .dataout(enc_code),
    .dispout(enc_rd)
  );
  // Counters reset to their last value so the first edge after release loads the comma
  always_comb begin
    tick = clkdiv_q == CLK_LAST;
    load = tick && bitcnt_q == BIT_LAST;
    clkdiv_d = tick ? '0 : clkdiv_q + 1'b1;
    bitcnt_d = load ? '0 : tick ? bitcnt_q + 1'b1 : bitcnt_q;
    symcnt_d = !load ? symcnt_q : symcnt_q == SYM_LAST ? '0 : symcnt_q + 1'b1;
    comma = symcnt_d == '0;
    enc_in = comma ? {1'b1, K28_5} : {1'b0, make_byte(i_IsPro, i_IsMaster, i_RawPls, i_Option)};
    shreg_d = load ? line_order(enc_code) : tick ? shreg_q >> 1 : shreg_q;
    rd_d = load ? rd_e'(enc_rd) : rd_q;
    pls_d = load ? i_RawPls && !comma : pls_q;
  end
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      clkdiv_q <= CLK_LAST;
      bitcnt_q <= BIT_LAST;
      symcnt_q <= SYM_LAST;
      shreg_q  <= '0;
      rd_q     <= RD_NEG;
      pls_q    <= 1'b0;
    end else begin
      clkdiv_q <= clkdiv_d;
      bitcnt_q <= bitcnt_d;
      symcnt_q <= symcnt_d;
      shreg_q  <= shreg_d;
      rd_q     <= rd_d;
      pls_q    <= pls_d;
    end
  end
  assign o_SerialData = shreg_q[0];
  assign o_tx_dis = 1'b0;
  assign o_tx_led = {pls_q, 1'b0};
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: randomized bench checking serial_tx every clock against a table-driven 8b/10b line model
module tb_serial_tx;
  import serial_pkg::*;
  localparam int CPB = 4;
  localparam int FL = 256;
  localparam int SYM_CLK = CPB * BITS_PER_SYM;
  localparam logic [5:0] T6N [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [5:0] T6P [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  localparam logic [3:0] T4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] T4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  serial_tx_if sif();
  serial_tx #(.CLK_PER_BIT(CPB), .FRAME_LEN(FL)) dut (
    .i_clk       (clk),
    .i_res_n     (rst_n),
    .i_IsPro     (sif.IsPro),
    .i_IsMaster  (sif.IsMaster),
    .i_RawPls    (sif.RawPls),
    .i_Option    (sif.Option),
    .o_SerialData(sif.SerialData),
    .o_tx_dis    (sif.tx_dis),
    .o_tx_led    (sif.tx_led)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
  endtask
  task automatic tmo(input string nm);
    n_chk++;
    $display("FAIL %s: timed out waiting at %0t", nm, $time);
  endtask
  function automatic logic [7:0] fields(input logic pro, mst, pls, input logic [2:0] opt);
    return {pro, mst, pls, ~^{pro, mst, pls}, opt, ~^opt};
  endfunction
  function automatic logic [9:0] model_sym(input logic k, input logic [7:0] b, input logic rd);
    logic [5:0] s6;
    logic [3:0] s4;
    logic r, alt;
    if (k) return rd ? K28_5_RDP : K28_5_RDN;
    s6 = rd ? T6P[b[4:0]] : T6N[b[4:0]];
    r = $countones(s6) > 3 ? 1'b1 : $countones(s6) < 3 ? 1'b0 : rd;
    alt = b[7:5] == 3'd7 && (r ? (b[4:0] == 5'd11 || b[4:0] == 5'd13 || b[4:0] == 5'd14)
                               : (b[4:0] == 5'd17 || b[4:0] == 5'd18 || b[4:0] == 5'd20));
    s4 = alt ? (r ? 4'b1000 : 4'b0111) : (r ? T4P[b[7:5]] : T4N[b[7:5]]);
    return {s6, s4};
  endfunction
  // Model: symbol s is latched at clock 40*s+1 after release, bit n held for clocks 4n+1..4n+4
  int m_cyc = 0;
  int m_sym = 0;
  logic m_rd = 1'b0, m_comma = 1'b0, m_pls = 1'b0, nxt_comma;
  logic [9:0] m_code = '0, nxt_code;
  assign nxt_comma = m_sym % FL == 0;
  assign nxt_code = model_sym(nxt_comma, fields(sif.IsPro, sif.IsMaster, sif.RawPls, sif.Option), m_rd);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc <= 0;
      m_sym <= 0;
      m_rd <= 1'b0;
      m_comma <= 1'b0;
      m_pls <= 1'b0;
      m_code <= '0;
    end else begin
      if (m_cyc % SYM_CLK == 0) begin
        m_code <= nxt_code;
        m_comma <= nxt_comma;
        m_pls <= sif.RawPls && !nxt_comma;
        m_rd <= $countones(nxt_code) > 5 ? 1'b1 : $countones(nxt_code) < 5 ? 1'b0 : m_rd;
        m_sym <= m_sym + 1;
      end
      m_cyc <= m_cyc + 1;
    end
  end
  int rx_bit = 0;
  int rx_sidx = 0;
  logic rx_rd = 1'b0;
  logic [9:0] rx_sh = '0, rx_full;
  logic [9:0] rx_syms[$];
  assign rx_full = {rx_sh[8:0], sif.SerialData};
  always @(negedge clk) begin
    chk("tx_dis", sif.tx_dis, 1'b0);
    chk("led_run", sif.tx_led[0], 1'b0);
    if (!rst_n) begin
      chk("line_in_reset", sif.SerialData, 1'b0);
      rx_bit <= 0;
      rx_sidx <= 0;
      rx_rd <= 1'b0;
      rx_syms.delete();
    end else if (m_cyc > 0) begin
      chk("line", sif.SerialData, m_code[9 - ((m_cyc - 1) % SYM_CLK) / CPB]);
      if (!m_comma) chk("led_pls", sif.tx_led[1], m_pls);
      if ((m_cyc - 1) % CPB == 1) begin
        rx_sh <= rx_full;
        if (rx_bit == 9) begin
          rx_syms.push_back(rx_full);
          chk("comma_pos", rx_full == K28_5_RDN || rx_full == K28_5_RDP, rx_sidx % FL == 0);
          chk("disparity", $countones(rx_full) == 5 || ($countones(rx_full) == 6 && !rx_rd)
                           || ($countones(rx_full) == 4 && rx_rd), 1'b1);
          rx_rd <= $countones(rx_full) == 6 ? 1'b1 : $countones(rx_full) == 4 ? 1'b0 : rx_rd;
          rx_sidx <= rx_sidx + 1;
          rx_bit <= 0;
        end else rx_bit <= rx_bit + 1;
      end
    end
  end
  task automatic wait_cyc(input int n);
    int t = 0;
    while (m_cyc != n && t < 40000) begin
      @(negedge clk);
      t++;
    end
    if (m_cyc != n) tmo("wait_cyc");
  endtask
  task automatic wait_rx(input int n);
    int t = 0;
    while (rx_syms.size() < n && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (rx_syms.size() < n) tmo("wait_rx");
  endtask
  task automatic set_in(input logic pro, mst, pls, input logic [2:0] opt);
    sif.IsPro = pro;
    sif.IsMaster = mst;
    sif.RawPls = pls;
    sif.Option = opt;
  endtask
  initial begin
    int t;
    set_in(0, 0, 0, 3'b000);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("model_byte_zero", fields(0, 0, 0, 3'b000), 8'h11);
    chk("model_byte_bb", fields(1, 0, 1, 3'b101), 8'hBB);
    chk("model_d17_0_rdp", model_sym(1'b0, 8'h11, 1'b1), 10'b1000110100);
    chk("model_d27_5_rdn", model_sym(1'b0, 8'hBB, 1'b0), 10'b1101101010);
    wait_cyc(2 * SYM_CLK + 20);
    sif.RawPls = 1'b1;
    wait_cyc(2 * SYM_CLK + 21);
    sif.RawPls = 1'b0;
    wait_cyc(3 * SYM_CLK + 20);
    chk("glitch_dropped", sif.tx_led[1], 1'b0);
    sif.RawPls = 1'b1;
    wait_cyc(4 * SYM_CLK + 10);
    chk("pls_held_led", sif.tx_led[1], 1'b1);
    sif.RawPls = 1'b0;
    wait_cyc(4 * SYM_CLK + 20);
    set_in(1, 0, 1, 3'b101);
    wait_cyc(5 * SYM_CLK + 10);
    set_in(0, 0, 0, 3'b000);
    wait_rx(6);
    if (rx_syms.size() >= 6) begin
      chk("sym0_k28_5_rdn", rx_syms[0], 10'b0011111010);
      chk("sym1_d17_0_rdp", rx_syms[1], 10'b1000110100);
      chk("sym2_d17_0_rdn", rx_syms[2], 10'b1000111011);
      chk("sym3_glitch_ignored", rx_syms[3], 10'b1000110100);
      chk("sym4_pls_set", rx_syms[4], 10'b0111011001);
      chk("sym5_byte_bb", rx_syms[5], 10'b0010011010);
    end
    while (m_cyc < 3 * FL * SYM_CLK + 2 * SYM_CLK) begin
      @(negedge clk);
      if ($urandom_range(15) == 0)
        set_in(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
    end
    chk("three_frames_seen", rx_sidx >= 3 * FL, 1'b1);
    t = 0;
    while (!(((m_cyc - 1) % SYM_CLK) inside {20, 21} && !m_comma && sif.SerialData) && t < 8000) begin
      @(negedge clk);
      if ($urandom_range(7) == 0)
        set_in(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
      t++;
    end
    if (t >= 8000) tmo("find_bit5_one");
    else begin
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk("abort_line", sif.SerialData, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_rx(2);
      if (rx_syms.size() >= 1) chk("restart_comma", rx_syms[0], K28_5_RDN);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/serial_tx.md
# serial_tx

Serial 8b/10b transmitter for the optical SFP link, running at 10 Mbps from the 40 MHz system clock. It is the sending end of the link whose receiver recovers IsPro, IsMaster, RawPls and Option. The block frames those control fields into parity-protected data bytes and inserts a K28.5 comma every 256 symbols so the far end can acquire symbol lock. It drives the SFP transmitter data and disable pins directly.

## Interface
- CLK_PER_BIT, default 4: system clocks per serial bit (40 MHz / 10 Mbps).
- FRAME_LEN, default 256: symbols per frame, comma included. The receiver's lock check requires exactly 2560 bits between commas.

- i_clk — in, 1 — 40 MHz system clock.
- i_res_n — in, 1 — asynchronous active-low reset.
- i_IsPro — in, 1 — field sent as data bit 7.
- i_IsMaster — in, 1 — field sent as data bit 6.
- i_RawPls — in, 1 — interrupter pulse, sent as data bit 5.
- i_Option — in, 3 — sent as data bits 3:1.
- o_SerialData — out, 1 — serial line to the SFP TXD pin.
- o_tx_dis — out, 1 — SFP TX_DISABLE. Constant 0.
- o_tx_led — out, 2 — [0] = 0, the TX "running" indicator (driven low); [1] = RawPls value of the symbol currently on the line.

## Operation
- Data byte: {i_IsPro, i_IsMaster, i_RawPls, p1, i_Option[2:0], p2}.
  - p1 = ~^{i_IsPro, i_IsMaster, i_RawPls}, so the XOR of bits 7:4 is 1.
  - p2 = ~^i_Option, so the XOR of bits 3:0 is 1.
- Frame layout: symbol 0 is K28.5 (K=1, byte 0xBC). Symbols 1..255 are data symbols.
- Running disparity (RD):
  - One register holds RD. It resets to RD− and is updated from the encoder's dispout at every symbol load, both K and D symbols.
  - At RD−, K28.5 is abcdei fghj = 001111 1010; at RD+ it is 110000 0101.
- Counters:
  - r_clkdiv: 0..CLK_PER_BIT−1. A bit tick occurs when r_clkdiv = CLK_PER_BIT−1.
  - r_bitcnt: 0..9.
  - r_symcnt: 0..FRAME_LEN−1, wraps to 0.
- Load: on a bit tick with r_bitcnt = 9.
  - r_symcnt increments and wraps.
  - The new symbol is encoded and placed into a 10-bit shift register as {j,h,g,f,i,e,d,c,b,a}.
  - r_bitcnt ← 0.
- Shift: on a bit tick with r_bitcnt < 9, shift right by 1 and r_bitcnt increments.
- o_SerialData is the shift register's bit 0, so bits go out in the order a,b,c,d,e,i,f,g,h,j.
- Inputs are sampled only on the load clock. Input changes mid-symbol do not affect the symbol in flight.
- Inputs are assumed synchronous to i_clk. Any synchronisation is the caller's responsibility.
- No error or backpressure path exists. The block free-runs from reset.

## Timing
- Reset values:
  - r_clkdiv = CLK_PER_BIT−1, r_bitcnt = 9, r_symcnt = FRAME_LEN−1.
  - Shift register = 0, so o_SerialData = 0.
  - RD = RD−, o_tx_led = 0, o_tx_dis = 0.
- The first rising edge after reset release is a load of symbol 0 (K28.5 at RD−). Bit a appears on o_SerialData after that edge.
- Each bit is held exactly CLK_PER_BIT clocks. A symbol lasts 40 clocks; a frame lasts 10240 clocks (2560 bits).
- Latency: an input change reaches the line at the next load. The worst case is 40 clocks, or 80 clocks if the next slot is the comma.
- Asynchronous reset mid-symbol aborts the symbol immediately. The line goes to 0, and the frame restarts with K28.5 at RD− after release.
- If r_symcnt wraps and a load occur on the same edge, the comma is selected, since the select is based on the post-increment value 0.

## Structure
- Package serial_pkg holds:
  - K28_5 = 8'hBC.
  - The K28.5 10-bit patterns for each RD.
  - BITS_PER_SYM = 10.
  - Data-bit field positions (PRO = 7, MST = 6, PLS = 5, P1 = 4, OPT = 3:1, P2 = 0), shared with the receiver.
- Sub-module encode_8b10b: combinational, with ports datain[8:0] (K flag in bit 8), dispin, dataout[9:0], dispout.
  - It is the counterpart of the existing decoder.
  - It is instantiated once. RD is registered in serial_tx.

## Test plan
- Reset release → the first 10 bits, sampled mid-bit every 4 clocks, are 0,0,1,1,1,1,1,0,1,0. Each bit lasts exactly 4 clocks.
- All inputs 0 → byte 0x11. The symbol after the comma (RD+) serializes as 1,0,0,0,1,1,0,1,0,0.
- IsPro = 1, IsMaster = 0, RawPls = 1, Option = 3'b101 → byte 0xBB. A reference decoder recovers the same fields, with both parity checks passing.
- Free run over 3 frames → every comma starts exactly 2560 bits (10240 clocks) after the previous one, and the RD sequence never shows a disparity error.
- Toggle i_RawPls for one clock mid-symbol → it is not transmitted. Holding it across a load clock → the next data symbol carries bit 5 = 1, and o_tx_led[1] = 1.
- Assert i_res_n low at bit 5 of a data symbol → o_SerialData = 0 immediately. After release, a K28.5 at RD− follows.
